// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential double-dabble binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Shift-add-3 correction: a digit of 5 or more would carry wrongly once doubled.
    function automatic logic [3:0] add3_correct(input logic [3:0] digit);
        if (digit >= 4'd5) begin
            return digit + 4'd3;
        end else begin
            return digit;
        end
    endfunction

    // Smallest digit count d with 10**d > 2**bin_w - 1 (valid for bin_w up to 59).
    function automatic int min_digits(input int bin_w);
        longint p2;
        longint p10;
        int     d;
        p2  = 64'sd1 <<< bin_w;
        p10 = 64'sd1;
        d   = 0;
        for (int i = 0; i < 20; i++) begin
            if (p10 < p2) begin
                p10 = p10 * 64'sd10;
                d   = d + 1;
            end else begin
                d   = d;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit slice: add-3 correction followed by a one-bit left shift.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       shift_in,
    output logic [3:0] digit_next,
    output logic       shift_out
);

    logic [3:0] corr_s;

    assign corr_s     = add3_correct(digit);
    assign digit_next = {corr_s[2:0], shift_in};
    assign shift_out  = corr_s[3];

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Iterative binary-to-BCD converter with start/ready request and valid/ack result handshakes.
// Optional BCD_EARLY_EXIT_EN skips leading zero bits so SHIFT lasts msb+1 cycles.
module binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          start_i,
    input  logic [BIN_W-1:0]              binary_i,
    output logic                          ready_o,
    output logic                          done_o,
    output logic                          valid_o,
    input  logic                          ack_i,
    output logic [4*DIGITS-1:0]           bcd_o,
    output logic [$clog2(DIGITS+1)-1:0]   digits_o
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int DIG_W = $clog2(DIGITS + 1);
    localparam int ACC_W = 4 * DIGITS;

    if (BIN_W < 2) begin : g_bin_w_check
        $error("binary_to_bcd_seq: BIN_W must be at least 2");
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
        $error("binary_to_bcd_seq: DIGITS too small to hold 2**BIN_W-1");
    end

    state_e             state_r;
    state_e             state_nxt_s;
    logic [BIN_W-1:0]   shift_reg_r;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ACC_W-1:0]   acc_shift_s;
    logic [DIGITS-1:0]  carry_s;
    logic               carry_unused_s;
    logic               load_s;
    logic               finish_s;
    logic [BIN_W-1:0]   load_value_s;
    logic [CNT_W-1:0]   load_cnt_s;
    logic [DIG_W-1:0]   digits_s;
    logic [ACC_W-1:0]   bcd_r;
    logic [DIG_W-1:0]   digits_r;
    logic               ready_r;
    logic               valid_r;
    logic               done_r;

    // The operand MSB enters digit 0; each digit's corrected MSB feeds the next digit up.
    assign carry_s[0] = shift_reg_r[BIN_W-1];
    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        if (g == DIGITS - 1) begin : g_top
            bcd_digit_cell u_cell (
                .digit      (acc_r[4*g +: 4]),
                .shift_in   (carry_s[g]),
                .digit_next (acc_shift_s[4*g +: 4]),
                .shift_out  (carry_unused_s)
            );
        end else begin : g_mid
            bcd_digit_cell u_cell (
                .digit      (acc_r[4*g +: 4]),
                .shift_in   (carry_s[g]),
                .digit_next (acc_shift_s[4*g +: 4]),
                .shift_out  (carry_s[g+1])
            );
        end
    end

`ifdef BCD_EARLY_EXIT_EN
    logic [CNT_W-1:0] msb_s;

    // Priority encoder and left-aligned preload so leading zeros cost no cycles.
    always_comb begin
        msb_s = {CNT_W{1'b0}};
        for (int i = 0; i < BIN_W; i++) begin
            if (binary_i[i]) begin
                msb_s = CNT_W'(i);
            end else begin
                msb_s = msb_s;
            end
        end
        load_value_s = binary_i << (CNT_W'(BIN_W - 1) - msb_s);
        load_cnt_s   = msb_s;
    end
`else
    assign load_value_s = binary_i;
    assign load_cnt_s   = CNT_W'(BIN_W - 1);
`endif

    // Significant-digit count of the result leaving the final shift.
    always_comb begin
        digits_s = DIG_W'(1);
        for (int i = 1; i < DIGITS; i++) begin
            if (acc_shift_s[4*i +: 4] != 4'd0) begin
                digits_s = DIG_W'(i + 1);
            end else begin
                digits_s = digits_s;
            end
        end
    end

    // Next-state logic and load/finish strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_nxt_s = SHIFT;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = HOLD;
                    finish_s    = 1'b1;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            HOLD: begin
                if (ack_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and handshake flags, registered from the next state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
            valid_r <= (state_nxt_s == HOLD);
            done_r  <= finish_s;
        end
    end

    // Conversion datapath and the result register, which only changes on SHIFT->HOLD.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shift_reg_r <= {BIN_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            bcd_r       <= {ACC_W{1'b0}};
            digits_r    <= DIG_W'(1);
        end else begin
            if (load_s) begin
                shift_reg_r <= load_value_s;
                acc_r       <= {ACC_W{1'b0}};
                cnt_r       <= load_cnt_s;
            end else if (state_r == SHIFT) begin
                shift_reg_r <= {shift_reg_r[BIN_W-2:0], 1'b0};
                acc_r       <= acc_shift_s;
                cnt_r       <= cnt_r - CNT_W'(1);
            end else begin
                shift_reg_r <= shift_reg_r;
                acc_r       <= acc_r;
                cnt_r       <= cnt_r;
            end
            if (finish_s) begin
                bcd_r    <= acc_shift_s;
                digits_r <= digits_s;
            end else begin
                bcd_r    <= bcd_r;
                digits_r <= digits_r;
            end
        end
    end

    assign ready_o  = ready_r;
    assign valid_o  = valid_r;
    assign done_o   = done_r;
    assign bcd_o    = bcd_r;
    assign digits_o = digits_r;

endmodule

// File: doc/binary_to_bcd_seq.md
Name: binary_to_bcd_seq

Overview:
- Iterative shift-add-3 (double-dabble) binary-to-BCD converter, parametrised in input width and digit count.
- Converts one unsigned word per transaction using a start/ready request handshake and a valid/ack result handshake.
- Holds each result until the consumer acknowledges it, and reports the count of significant digits for display blanking.
- Feeds seven-segment and display-formatting stages in counter and frequency-meter designs.

Parameters:
- BIN_W, 16, input binary width in bits (>=2).
- DIGITS, 5, BCD output digit count. Elaboration must fail unless 10**DIGITS > 2**BIN_W - 1.

Ports:
- clk_i  input  1  system clock, rising edge
- reset_ni  input  1  reset; asynchronous assert, active-low
- start_i  input  1  request conversion; sampled only while ready_o=1
- binary_i  input  BIN_W  unsigned operand; captured on the accepted start
- ready_o  output  1  converter idle, can accept start_i
- done_o  output  1  one-cycle pulse on the first cycle a new result is valid
- valid_o  output  1  bcd_o/digits_o hold a fresh, unacknowledged result
- ack_i  input  1  consumer accepts the result; meaningful only while valid_o=1
- bcd_o  output  4*DIGITS  packed BCD result; digit 0 in [3:0]
- digits_o  output  $clog2(DIGITS+1)  significant-digit count, 1..DIGITS

Behaviour:
- Interface: one clock (clk_i); reset_ni is asynchronous and active-low. Both are fixed.
- Reset values: state=IDLE, ready_o=1, done_o=0, valid_o=0, bcd_o=0, digits_o=1. Reset mid-operation aborts immediately and discards any partial result.
- States:
  - IDLE: ready_o=1. start_i=1 loads shift_reg<=binary_i, acc<=0, cnt<=BIN_W-1, then moves to SHIFT.
  - SHIFT: ready_o=0. Each cycle, every digit of acc that is >=5 gets +3 (all digits in parallel). Then {acc,shift_reg} shifts left by 1. After the shift with cnt==0, go to HOLD and register the result; otherwise decrement cnt. start_i is ignored.
  - HOLD: valid_o=1, ready_o=0. ack_i=1 clears valid_o and returns to IDLE on the next edge. start_i is ignored, including when it arrives together with ack_i. bcd_o/digits_o stay stable for the whole of HOLD.
- Latency: start accepted at edge E0 -> valid_o and done_o high after edge E0+BIN_W. Minimum throughput is one conversion per BIN_W+2 cycles with ack_i tied high.
- Correction happens before the shift, so every digit stays in 0..9. The top digit can never exceed 9 given the parameter check; no overflow flag.
- Result register:
  - bcd_o and digits_o are registered, not combinational. They update only on the SHIFT->HOLD transition.
  - They keep their value through IDLE and the following SHIFT, so the last result stays displayable.
- digits_o = index of the most significant non-zero digit + 1. For a result of 0, digits_o=1.
- Back-to-back: a start in the first IDLE cycle after ack is accepted normally. No cycle gap is required beyond the IDLE state itself.

Optional Feature:
- Macro: BCD_EARLY_EXIT_EN.
- Defined:
  - On the accepted start, a priority encoder finds msb = index of the highest set bit of binary_i.
  - shift_reg is preloaded left-aligned (binary_i << (BIN_W-1-msb)) and cnt<=msb.
  - SHIFT therefore lasts msb+1 cycles. For binary_i=0 it lasts 1 cycle.
  - Results are identical to the non-EE build; only latency changes.
- Undefined: fixed BIN_W-cycle latency and no priority encoder logic.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE, SHIFT, HOLD), logic [1:0].
  - function add3_correct(logic [3:0]) returning [3:0].
  - function min_digits(int bin_w), used for the elaboration check.
- Sub-module bcd_digit_cell:
  - One digit per instance, instantiated DIGITS times in a generate loop.
  - Inputs: 4-bit digit, shift-in bit. Outputs: corrected-and-shifted digit, shift-out bit (MSB of the corrected digit).

Test Plan:
- Zero: BIN_W=16, DIGITS=5, binary_i=0, ack_i=1 -> done_o pulses exactly 16 cycles after the accepting edge; bcd_o=20'h00000, digits_o=1.
- Full scale: binary_i=65535 -> bcd_o=20'h65535, digits_o=5. A follow-up binary_i=1234 -> bcd_o=20'h01234, digits_o=4.
- Backpressure: ack_i low for 10 cycles after valid_o -> valid_o, bcd_o and digits_o stay stable; start_i pulses are ignored and ready_o stays 0. Raising ack_i for one cycle -> ready_o=1 next cycle.
- Reset mid-SHIFT: drop reset_ni in the 8th SHIFT cycle -> ready_o=1, valid_o=0, bcd_o=0, digits_o=1 asynchronously. A new conversion of 42 -> 20'h00042.
- Reparametrised: BIN_W=8, DIGITS=3, binary_i=255 -> bcd_o=12'h255, latency 8 cycles. A separate build with BIN_W=8, DIGITS=2 must fail elaboration.
- With BCD_EARLY_EXIT_EN: binary_i=5 (BIN_W=16) -> done_o 3 cycles after the accepting edge, bcd_o=20'h00005. binary_i=0 -> done_o after 1 cycle.
